// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Optional feature macro: ILLEGAL_OP_HALT_EN (adds the HALT state).
package riscv_pkg;

    localparam int unsigned OP_W     = 7;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned ALUC_W   = 3;
    localparam int unsigned STATE_W  = 4;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BEQ
`ifdef ILLEGAL_OP_HALT_EN
        , S_HALT
`endif
    } mc_state_t;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [ALUC_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational ALU decoder: alu_op plus instruction fields to ALU function.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [ALUOP_W-1:0] alu_op_i,
    input  logic [F3_W-1:0]    funct3_i,
    input  logic               op5_i,
    input  logic               funct7b5_i,
    output logic [ALUC_W-1:0]  alu_control_o
);

    // Map the requested ALU operation; funct3 only matters for alu_op 10.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for the multicycle RV32I core.
// Optional feature macro: ILLEGAL_OP_HALT_EN (unknown opcodes halt the core).
module mc_controller
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   op,
    input  logic [F3_W-1:0]   funct3,
    input  logic              funct7b5,
    input  logic              zero,
    output logic [SEL_W-1:0]  imm_src,
    output logic [SEL_W-1:0]  alu_src_a,
    output logic [SEL_W-1:0]  alu_src_b,
    output logic [SEL_W-1:0]  result_src,
    output logic              adr_src,
    output logic [ALUC_W-1:0] alu_control,
    output logic              ir_write,
    output logic              pc_write,
    output logic              reg_write,
    output logic              mem_write,
    output logic              halted
);

    mc_state_t          state_q, state_d;
    logic [ALUOP_W-1:0] alu_op;
    logic               ir_write_s, reg_write_s, mem_write_s;
    logic               pc_update, branch;

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BEQ;
`ifdef ILLEGAL_OP_HALT_EN
                    default:           state_d = S_HALT;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
`ifdef ILLEGAL_OP_HALT_EN
            S_HALT:     state_d = S_HALT;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore output decode; unlisted fields stay at zero.
    always_comb begin
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        adr_src     = 1'b0;
        alu_op      = ALUOP_ADD;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        pc_update   = 1'b0;
        branch      = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write_s = 1'b1;
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
`ifdef ILLEGAL_OP_HALT_EN
            S_HALT: halted = 1'b1;
`endif
            default: ;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    // Write enables are suppressed for as long as reset is held.
    assign ir_write  = ir_write_s  & ~reset;
    assign reg_write = reg_write_s & ~reset;
    assign mem_write = mem_write_s & ~reset;
    assign pc_write  = (pc_update | (branch & zero)) & ~reset;

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .op5_i         (op[5]),
        .funct7b5_i    (funct7b5),
        .alu_control_o (alu_control)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each driven cycle pushes the expected
// control word, a monitor pops and compares on the falling edge.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [1:0] imm_src, alu_src_a, alu_src_b, result_src;
    logic       adr_src;
    logic [2:0] alu_control;
    logic       ir_write, pc_write, reg_write, mem_write, halted;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .adr_src(adr_src), .alu_control(alu_control),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .mem_write(mem_write), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] imm;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] res;
        logic       adr;
        logic [2:0] alu;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic       halt;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BEQ = 5, K_ILL = 6;

    function automatic logic [6:0] opcode_of(int kind);
        case (kind)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_JAL:   return 7'b1101111;
            K_BEQ:   return 7'b1100011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // ALU function an R/I instruction asks for.
    function automatic logic [2:0] alu_fn(logic [2:0] f3, logic op5, logic f7);
        case (f3)
            3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int len_of(int kind);
        case (kind)
            K_LW:    return 5;
            K_BEQ:   return 3;
            K_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic exp_t quiet_vec(logic [6:0] o);
        exp_t e = '0;
        e.imm = imm_of(o);
        return e;
    endfunction

    function automatic exp_t reset_vec(logic [6:0] o);
        exp_t e = quiet_vec(o);
        e.b   = 2'b10;
        e.res = 2'b10;
        return e;
    endfunction

    // Expected control word for cycle idx (0 = fetch) of one instruction.
    function automatic exp_t expect_cycle(int kind, int idx, logic [6:0] o,
                                          logic [2:0] f3, logic f7, logic z);
        exp_t e = quiet_vec(o);
        if (idx == 0) begin
            e = reset_vec(o);
            e.irw = 1'b1;
            e.pcw = 1'b1;
        end else if (idx == 1) begin
            e.a = 2'b01;
            e.b = 2'b01;
        end else begin
            case (kind)
                K_LW: begin
                    if (idx == 2) begin e.a = 2'b10; e.b = 2'b01; end
                    else if (idx == 3) e.adr = 1'b1;
                    else begin e.res = 2'b01; e.rw = 1'b1; end
                end
                K_SW: begin
                    if (idx == 2) begin e.a = 2'b10; e.b = 2'b01; end
                    else begin e.adr = 1'b1; e.mw = 1'b1; end
                end
                K_R, K_I: begin
                    if (idx == 2) begin
                        e.a   = 2'b10;
                        e.b   = (kind == K_I) ? 2'b01 : 2'b00;
                        e.alu = alu_fn(f3, o[5], f7);
                    end else e.rw = 1'b1;
                end
                K_JAL: begin
                    if (idx == 2) begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; end
                    else e.rw = 1'b1;
                end
                K_BEQ: begin
                    e.a   = 2'b10;
                    e.alu = 3'b001;
                    e.pcw = z;
                end
                default: e.halt = 1'b1;
            endcase
        end
        return e;
    endfunction

    task automatic drive_cycle(logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                               logic rst, exp_t e);
        @(posedge clk);
        #1;
        reset    = rst;
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        zero     = z;
        sb.push_back(e);
    endtask

    // zmode: 0/1 forces zero, 2 randomizes it every cycle.
    task automatic run_instr(int kind, logic [6:0] o, logic [2:0] f3, logic f7, int zmode);
        logic z;
        for (int idx = 0; idx < len_of(kind); idx++) begin
            z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            drive_cycle(o, f3, f7, z, 1'b0, expect_cycle(kind, idx, o, f3, f7, z));
        end
    endtask

    task automatic sw_with_reset();
        logic [6:0] o = opcode_of(K_SW);
        for (int idx = 0; idx < 3; idx++)
            drive_cycle(o, 3'b010, 1'b0, 1'b0, 1'b0, expect_cycle(K_SW, idx, o, 3'b010, 1'b0, 1'b0));
        drive_cycle(o, 3'b010, 1'b0, 1'b1, 1'b1, reset_vec(o));
        drive_cycle(o, 3'b010, 1'b0, 1'b1, 1'b1, reset_vec(o));
    endtask

    function automatic logic [6:0] illegal_op();
        logic [6:0] o;
        do begin
            o = 7'($urandom_range(0, 127));
        end while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
                   o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011);
        return o;
    endfunction

    // Monitor: compare the DUT against the oldest expected word.
    initial begin
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                got.imm = imm_src;   got.a = alu_src_a;  got.b = alu_src_b;
                got.res = result_src; got.adr = adr_src; got.alu = alu_control;
                got.irw = ir_write;  got.pcw = pc_write; got.rw = reg_write;
                got.mw = mem_write;  got.halt = halted;
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL ctrl_word t=%0t op=%b f3=%b f7=%b z=%b rst=%b: got imm=%b a=%b b=%b res=%b adr=%b alu=%b irw=%b pcw=%b rw=%b mw=%b halt=%b, expected imm=%b a=%b b=%b res=%b adr=%b alu=%b irw=%b pcw=%b rw=%b mw=%b halt=%b",
                             $time, op, funct3, funct7b5, zero, reset,
                             got.imm, got.a, got.b, got.res, got.adr, got.alu, got.irw, got.pcw, got.rw, got.mw, got.halt,
                             e.imm, e.a, e.b, e.res, e.adr, e.alu, e.irw, e.pcw, e.rw, e.mw, e.halt);
                end
            end
        end
    end

    // Stimulus: reset, directed cases, random instruction stream.
    initial begin
        int kind;
        reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
        repeat (3) drive_cycle(7'b0, 3'b0, 1'b0, 1'b0, 1'b1, reset_vec(7'b0));

        run_instr(K_LW,  opcode_of(K_LW),  3'b010, 1'b0, 2);
        run_instr(K_BEQ, opcode_of(K_BEQ), 3'b000, 1'b0, 1);
        run_instr(K_BEQ, opcode_of(K_BEQ), 3'b000, 1'b0, 0);
        run_instr(K_R,   opcode_of(K_R),   3'b000, 1'b1, 2);
        run_instr(K_I,   opcode_of(K_I),   3'b000, 1'b1, 2);
        run_instr(K_I,   opcode_of(K_I),   3'b110, 1'b0, 2);
        run_instr(K_R,   opcode_of(K_R),   3'b111, 1'b0, 2);
        run_instr(K_JAL, opcode_of(K_JAL), 3'b000, 1'b0, 2);
        run_instr(K_SW,  opcode_of(K_SW),  3'b010, 1'b0, 2);
        sw_with_reset();
        run_instr(K_LW,  opcode_of(K_LW),  3'b010, 1'b0, 2);
`ifndef ILLEGAL_OP_HALT_EN
        run_instr(K_ILL, 7'b0000000, 3'b000, 1'b0, 2);
        run_instr(K_SW,  opcode_of(K_SW),  3'b010, 1'b0, 2);
`endif

        for (int n = 0; n < 150; n++) begin
`ifdef ILLEGAL_OP_HALT_EN
            kind = $urandom_range(0, 5);
`else
            kind = $urandom_range(0, 6);
`endif
            run_instr(kind, (kind == K_ILL) ? illegal_op() : opcode_of(kind),
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2);
        end

`ifdef ILLEGAL_OP_HALT_EN
        run_instr(K_ILL, 7'b0000000, 3'b000, 1'b0, 2);
        repeat (20) drive_cycle(7'b0, 3'b000, 1'b0, 1'($urandom_range(0, 1)), 1'b0,
                                expect_cycle(K_ILL, 2, 7'b0, 3'b000, 1'b0, 1'b0));
        repeat (2) drive_cycle(7'b0, 3'b000, 1'b0, 1'b0, 1'b1, reset_vec(7'b0));
        run_instr(K_LW, opcode_of(K_LW), 3'b010, 1'b0, 2);
`endif

        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Main control unit for the multicycle RV32I core. A Moore state machine sequences the shared datapath (one ALU, one unified memory port, IR/OldPC/A/B/ALUOut/Data registers) through fetch, decode, execute, memory and writeback. It sits beside the datapath inside the multicycle core top. It decodes `op`, `funct3` and `funct7b5` from the instruction register, takes `zero` from the ALU, and drives every mux select and write enable.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high reset.
- `op`  in  7  IR[6:0].
- `funct3`  in  3  IR[14:12].
- `funct7b5`  in  1  IR[30].
- `zero`  in  1  ALU result == 0.
- `imm_src`  out  2  00 I, 01 S, 10 B, 11 J.
- `alu_src_a`  out  2  00 PC, 01 OldPC, 10 A.
- `alu_src_b`  out  2  00 B (rs2), 01 ImmExt, 10 constant 4.
- `result_src`  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- `adr_src`  out  1  0 PC, 1 Result.
- `alu_control`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ir_write`, `pc_write`, `reg_write`, `mem_write`  out  1 each  write enables.
- `halted`  out  1  illegal-opcode halt flag; see Configuration.

## Operation
- States and their transitions:
  - FETCH: adr_src 0, ir_write 1, a 00, b 10, alu_op 00, result_src 10, pc_update 1. Next: DECODE.
  - DECODE: a 01, b 01, alu_op 00 (branch target). Next depends on `op`:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1101111 → JAL.
    - 1100011 → BEQ.
    - Any other opcode: see Configuration.
  - MEMADR: a 10, b 01, alu_op 00. Next: MEMREAD if `op`=0000011, else MEMWRITE.
  - MEMREAD: result_src 00, adr_src 1. Next: MEMWB.
  - MEMWB: result_src 01, reg_write 1. Next: FETCH.
  - MEMWRITE: result_src 00, adr_src 1, mem_write 1. Next: FETCH.
  - EXECUTER: a 10, b 00, alu_op 10. Next: ALUWB.
  - EXECUTEI: a 10, b 01, alu_op 10. Next: ALUWB.
  - ALUWB: result_src 00, reg_write 1. Next: FETCH.
  - JAL: a 01, b 10, alu_op 00, result_src 00, pc_update 1. Next: ALUWB.
  - BEQ: a 10, b 00, alu_op 01, result_src 00, branch 1. Next: FETCH.
- Any field not listed for a state is 0.
- `pc_write = pc_update | (branch & zero)`.
- `imm_src` is combinational from `op` in every state:
  - 0100011 → 01.
  - 1100011 → 10.
  - 1101111 → 11.
  - Everything else → 00.
- ALU decoder (`alu_control`):
  - alu_op 00 → add.
  - alu_op 01 → sub.
  - alu_op 10, by `funct3`:
    - 000 → sub if op[5] & funct7b5, else add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.
    - Other funct3 → add.

## Timing
- Reset: state ← FETCH asynchronously.
- While `reset`=1, `ir_write`, `pc_write`, `reg_write` and `mem_write` are forced 0, overriding the state decode. Select outputs show FETCH values. `halted`=0.
- First FETCH executes on the first rising edge after `reset` deasserts.
- Outputs are Moore and change only on the clock edge. Exceptions: `pc_write` follows `zero` combinationally in BEQ; `imm_src` and `alu_control` follow the decode inputs.
- Cycles per instruction, FETCH through last state inclusive:
  - lw 5.
  - sw, R-type, I-ALU, jal 4.
  - beq 3.
- Exactly one of `reg_write`/`mem_write` pulses per load/store/ALU instruction, for one cycle only.
- Reset asserted mid-instruction aborts it immediately; no partial write enable is held.

## Configuration
- `ILLEGAL_OP_HALT_EN` defined:
  - An unrecognised opcode in DECODE → HALT.
  - HALT drives all enables 0 and `halted`=1, and stays there until reset.
- `ILLEGAL_OP_HALT_EN` undefined:
  - An unrecognised opcode in DECODE → FETCH, so the instruction is a 2-cycle nop. PC was already advanced in FETCH.
  - HALT state is not compiled; `halted` is tied 0.

## Structure
- `riscv_pkg` holds:
  - State enum `mc_state_t`.
  - Opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH).
  - `alu_control` and `alu_op` encodings.
- Sub-module `alu_decoder` (alu_op, funct3, op5, funct7b5 → alu_control), purely combinational.
- `mc_controller` holds the state register, next-state logic, output decode and imm_src decode.

## Test plan
- Reset: hold `reset` 3 cycles → all write enables 0. Release → FETCH, with ir_write=1, pc_write=1, alu_src_b=10, result_src=10.
- lw (op=0000011, funct3=010) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 only in cycle 5, with result_src=01. adr_src=1 in cycle 4.
- beq (op=1100011): zero=1 → pc_write=1 in cycle 3 with alu_control=001. zero=0 → pc_write=0. Next cycle is FETCH in both cases.
- R-type funct3=000, funct7b5=1 → alu_control=001 in EXECUTER. addi (op=0010011) with funct7b5=1 → alu_control=000. funct3=110 → 011.
- sw (op=0100011) → imm_src=01, mem_write=1 for exactly cycle 4. Repeat with `reset` asserted during MEMWRITE → mem_write falls the same cycle, state=FETCH.
- op=0000000 with `ILLEGAL_OP_HALT_EN` → HALT, halted=1 for 20 cycles, no enables. Without the macro → FETCH in cycle 3, halted=0.
